axi_fifo_drain_writer: RTL and testbench

//  FIFO reader + AXI4 write master, read-clock side of the UART-to-DDR path. Pops DATA_WIDTH words from the

---
 rtl/axi_drain_pkg.sv | 20 ++
 rtl/drain_pack_buf.sv | 46 ++++
 rtl/axi_fifo_drain_writer.sv | 171 +++++++++++++++++
 tb/tb_axi_fifo_drain_writer.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_drain_pkg.sv
// rtl/axi_drain_pkg.sv - shared FSM states, AXI constants and helpers for the FIFO drain writer
package axi_drain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ADDR,
    DATA,
    RESP
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI AxSIZE encoding for a bus of the given bit width
  function automatic logic [2:0] axi_size(input int axi_data_width);
    return 3'($clog2(axi_data_width / 8));
  endfunction

endpackage

// File: rtl/drain_pack_buf.sv
// rtl/drain_pack_buf.sv - one-burst lane/beat packing buffer with strobe generation
module drain_pack_buf #(
  parameter int DATA_WIDTH     = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN      = 4,
  parameter int CNT_W          = 5,
  parameter int BEAT_W         = 2
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [CNT_W-1:0]            wr_idx,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [BEAT_W-1:0]           rd_beat,
  input  logic [CNT_W-1:0]            fill_cnt,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic [AXI_DATA_WIDTH/8-1:0] rd_strb
);

  localparam int LANES      = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int TOTAL      = BURST_LEN * LANES;
  localparam int IDX_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int LANE_BYTES = DATA_WIDTH / 8;

  // Sized to a power of two so every index value is in range.
  logic [DATA_WIDTH-1:0] mem [2**IDX_W];

  // Word storage; stale contents are never read because reads are masked by fill_cnt.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[IDX_W'(wr_idx)] <= wr_data;
    end
  end

  // Assemble the requested beat; lanes beyond the captured count read as zero with strobe low.
  always_comb begin
    rd_data = '0;
    rd_strb = '0;
    for (int l = 0; l < LANES; l++) begin
      if ((int'(rd_beat) * LANES + l) < int'(fill_cnt)) begin
        rd_data[l*DATA_WIDTH +: DATA_WIDTH] = mem[IDX_W'(int'(rd_beat) * LANES + l)];
        rd_strb[l*LANE_BYTES +: LANE_BYTES] = '1;
      end
    end
  end

endmodule

// File: rtl/axi_fifo_drain_writer.sv
// rtl/axi_fifo_drain_writer.sv - FIFO reader and AXI4 burst write master; DRAIN_FLUSH_EN adds partial-burst flush
module axi_fifo_drain_writer
  import axi_drain_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    AXI_DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    BURST_LEN      = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    REGION_BYTES   = 4096
) (
  input  logic                        rclk,
  input  logic                        rst,
`ifdef DRAIN_FLUSH_EN
  input  logic                        flush,
`endif
  output logic                        fifo_r_en,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  output logic [ADDR_WIDTH-1:0]       awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready,
  output logic                        busy,
  output logic                        err
);

  localparam int LANES       = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int TOTAL       = BURST_LEN * LANES;
  localparam int CNT_W       = $clog2(TOTAL + 1);
  localparam int CW1         = CNT_W + 1;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_BYTES = BURST_LEN * AXI_DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] REGION_END = BASE_ADDR + ADDR_WIDTH'(REGION_BYTES);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        issued_q;
  logic [CNT_W-1:0]        captured_q;
  logic                    pop_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    err_q;
  logic                    flush_stop;
  logic [CW1-1:0]          beats_used;

  // Burst length follows the captured word count, so a flushed burst is shortened automatically.
  assign beats_used = ({1'b0, captured_q} + CW1'(LANES - 1)) / CW1'(LANES);
  assign awlen      = 8'(beats_used - CW1'(1));
  assign awaddr     = addr_q;
  assign awsize     = axi_size(AXI_DATA_WIDTH);
  assign awburst    = AXI_BURST_INCR;
  assign wlast      = (state_q == DATA) && (8'(beat_q) == awlen);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign addr_next  = (addr_q + ADDR_STEP == REGION_END) ? BASE_ADDR : addr_q + ADDR_STEP;

`ifdef DRAIN_FLUSH_EN
  logic flush_q;

  // Pops stop once a flush is accepted; it only counts in FILL with at least one word captured.
  assign flush_stop = (state_q == FILL) && (flush_q || (flush && captured_q != '0));

  // Remember an accepted flush while a pop issued just before it is still landing.
  always_ff @(posedge rclk) begin
    if (rst) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush_stop && (state_d == FILL);
    end
  end
`else
  assign flush_stop = 1'b0;
`endif

  // State register.
  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; AW, W and B phases are strictly sequential.
  always_comb begin
    state_d   = state_q;
    fifo_r_en = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FILL;
      end
      FILL: begin
        fifo_r_en = !fifo_empty && (issued_q < CNT_W'(TOTAL)) && !flush_stop;
        if (captured_q == CNT_W'(TOTAL)) begin
          state_d = ADDR;
        end else if (flush_stop && !pop_q) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = DATA;
      end
      DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) state_d = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = fifo_empty ? IDLE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop/capture counters, beat index, region address pointer and sticky error flag.
  always_ff @(posedge rclk) begin
    if (rst) begin
      issued_q   <= '0;
      captured_q <= '0;
      pop_q      <= 1'b0;
      beat_q     <= '0;
      addr_q     <= BASE_ADDR;
      err_q      <= 1'b0;
    end else begin
      pop_q <= fifo_r_en && !fifo_empty;
      if (fifo_r_en && !fifo_empty) issued_q <= issued_q + CNT_W'(1);
      if (pop_q) captured_q <= captured_q + CNT_W'(1);
      if (wvalid && wready) beat_q <= wlast ? '0 : beat_q + BEAT_W'(1);
      if (bready && bvalid) begin
        if (bresp != AXI_RESP_OKAY) err_q <= 1'b1;
        addr_q     <= addr_next;
        issued_q   <= '0;
        captured_q <= '0;
      end
    end
  end

  drain_pack_buf #(
    .DATA_WIDTH    (DATA_WIDTH),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .BURST_LEN     (BURST_LEN),
    .CNT_W         (CNT_W),
    .BEAT_W        (BEAT_W)
  ) u_buf (
    .clk     (rclk),
    .wr_en   (pop_q),
    .wr_idx  (captured_q),
    .wr_data (fifo_data),
    .rd_beat (beat_q),
    .fill_cnt(captured_q),
    .rd_data (wdata),
    .rd_strb (wstrb)
  );

endmodule

// File: tb/tb_axi_fifo_drain_writer.sv
// tb/tb_axi_fifo_drain_writer.sv - directed self-checking bench; flush scenario built when DRAIN_FLUSH_EN is defined
module tb_axi_fifo_drain_writer;

  logic        rclk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_r_en;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        busy;
  logic        err;
`ifdef DRAIN_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 rclk = ~rclk;

  axi_fifo_drain_writer #(
    .DATA_WIDTH    (8),
    .AXI_DATA_WIDTH(32),
    .ADDR_WIDTH    (32),
    .BURST_LEN     (4),
    .BASE_ADDR     (32'h0000_1000),
    .REGION_BYTES  (32)
  ) dut (
    .rclk      (rclk),
    .rst       (rst),
`ifdef DRAIN_FLUSH_EN
    .flush     (flush),
`endif
    .fifo_r_en (fifo_r_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .busy      (busy),
    .err       (err)
  );

  // FIFO model: data appears the cycle after an accepted pop
  logic [7:0] fmem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rclk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // B channel slave: one response after each last W beat
  logic [1:0] resp_cfg = 2'b00;
  always @(posedge rclk) begin
    if (rst) begin
      bvalid <= 1'b0;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end else if (wvalid && wready && wlast) begin
      bvalid <= 1'b1;
      bresp  <= resp_cfg;
    end
  end

  // Handshake recorder
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q  [$];
  logic [2:0]  aw_size_q [$];
  logic [1:0]  aw_burst_q[$];
  logic [31:0] w_data_q  [$];
  logic [3:0]  w_strb_q  [$];
  logic        w_last_q  [$];

  always @(negedge rclk) begin
    if (!rst && awvalid && awready) begin
      aw_addr_q.push_back(awaddr);
      aw_len_q.push_back(awlen);
      aw_size_q.push_back(awsize);
      aw_burst_q.push_back(awburst);
    end
    if (!rst && wvalid && wready) begin
      w_data_q.push_back(wdata);
      w_strb_q.push_back(wstrb);
      w_last_q.push_back(wlast);
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr] = first + 8'(i);
      wr_ptr++;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while ((busy || !fifo_empty) && k < budget);
    n_checks++;
    if (busy || !fifo_empty) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%0b empty=%0b, required idle within %0d cycles", name, busy, fifo_empty, budget);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    rst = 1'b1;
    @(negedge rclk);
    n_checks++;
    if ({awvalid, wvalid, bready, fifo_r_en, busy, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: {awv,wv,bready,r_en,busy,err}=%b, required 000000",
               {awvalid, wvalid, bready, fifo_r_en, busy, err});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_full_burst();
    logic [31:0] exp_w [4];
    int a0, w0;
    exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    a0 = aw_addr_q.size();
    w0 = w_data_q.size();
    awready = 1'b1;
    wready = 1'b1;
    resp_cfg = 2'b00;
    push_bytes(8'h00, 16);
    wait_idle("full", 200);
    n_checks++;
    if (aw_addr_q.size() != a0 + 1) begin
      n_fail++;
      $display("FAIL full_aw_count: got %0d, required 1", aw_addr_q.size() - a0);
    end else begin
      n_checks++;
      if (aw_addr_q[a0] !== 32'h1000) begin
        n_fail++;
        $display("FAIL full_awaddr: got %h, required 00001000", aw_addr_q[a0]);
      end
      n_checks++;
      if ({aw_len_q[a0], aw_size_q[a0], aw_burst_q[a0]} !== {8'd3, 3'd2, 2'b01}) begin
        n_fail++;
        $display("FAIL full_awctl: len=%0d size=%0d burst=%0d, required 3 2 1",
                 aw_len_q[a0], aw_size_q[a0], aw_burst_q[a0]);
      end
    end
    n_checks++;
    if (w_data_q.size() != w0 + 4) begin
      n_fail++;
      $display("FAIL full_w_count: got %0d, required 4", w_data_q.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (w_data_q[w0+i] !== exp_w[i] || w_strb_q[w0+i] !== 4'hF || w_last_q[w0+i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL full_beat%0d: data=%h strb=%h last=%b, required %h f %b",
                   i, w_data_q[w0+i], w_strb_q[w0+i], w_last_q[w0+i], exp_w[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_stall();
    int a0, w0, aw_cyc;
    logic prev_aw, prev_w, done;
    logic [31:0] prev_addr, prev_data;
    a0 = aw_addr_q.size();
    w0 = w_data_q.size();
    aw_cyc = 0;
    prev_aw = 1'b0;
    prev_w = 1'b0;
    done = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    awready = 1'b0;
    wready = 1'b0;
    push_bytes(8'h10, 16);
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (aw_cyc >= 5) awready = 1'b1;
      wready = !wready;
      @(negedge rclk);
      if (prev_aw) begin
        n_checks++;
        if (!awvalid || awaddr !== prev_addr) begin
          n_fail++;
          $display("FAIL stall_aw_stable: awvalid=%b awaddr=%h, required 1 %h", awvalid, awaddr, prev_addr);
        end
      end
      if (prev_w) begin
        n_checks++;
        if (!wvalid || wdata !== prev_data) begin
          n_fail++;
          $display("FAIL stall_w_stable: wvalid=%b wdata=%h, required 1 %h", wvalid, wdata, prev_data);
        end
      end
      if (awvalid && !awready) aw_cyc++;
      prev_aw = awvalid && !awready;
      prev_addr = awaddr;
      prev_w = wvalid && !wready;
      prev_data = wdata;
      if (c > 2 && !busy && fifo_empty) done = 1'b1;
    end
    awready = 1'b1;
    wready = 1'b1;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL stall_timeout: busy=%b, required idle", busy);
    end
    n_checks++;
    if (aw_cyc != 5) begin
      n_fail++;
      $display("FAIL stall_aw_wait: got %0d cycles, required 5", aw_cyc);
    end
    n_checks++;
    if (w_data_q.size() != w0 + 4 || aw_addr_q.size() != a0 + 1) begin
      n_fail++;
      $display("FAIL stall_counts: w=%0d aw=%0d, required 4 1", w_data_q.size() - w0, aw_addr_q.size() - a0);
    end else begin
      n_checks++;
      if (aw_addr_q[a0] !== 32'h1010 || w_data_q[w0+3] !== 32'h1F1E1D1C) begin
        n_fail++;
        $display("FAIL stall_content: awaddr=%h last=%h, required 00001010 1f1e1d1c", aw_addr_q[a0], w_data_q[w0+3]);
      end
    end
  endtask

  task automatic test_err();
    int a0;
    a0 = aw_addr_q.size();
    resp_cfg = 2'b10;
    push_bytes(8'h20, 16);
    wait_idle("err1", 200);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b, required 1", err);
    end
    for (int i = 0; i < 3; i++) tick();
    resp_cfg = 2'b00;
    push_bytes(8'h30, 16);
    wait_idle("err2", 200);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    n_checks++;
    if (aw_addr_q.size() != a0 + 2) begin
      n_fail++;
      $display("FAIL err_aw_count: got %0d, required 2", aw_addr_q.size() - a0);
    end else begin
      n_checks++;
      if (aw_addr_q[a0] !== 32'h1000 || aw_addr_q[a0+1] !== 32'h1010) begin
        n_fail++;
        $display("FAIL err_addrs: got %h %h, required 00001000 00001010", aw_addr_q[a0], aw_addr_q[a0+1]);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    int a0, w0, k;
    awready = 1'b1;
    wready = 1'b0;
    push_bytes(8'h40, 16);
    k = 0;
    do begin
      @(negedge rclk);
      k++;
    end while (!wvalid && k < 100);
    n_checks++;
    if (!wvalid) begin
      n_fail++;
      $display("FAIL middata_reach: wvalid=%b, required 1", wvalid);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge rclk);
    n_checks++;
    if ({awvalid, wvalid, bready, fifo_r_en, busy, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL middata_outputs: {awv,wv,bready,r_en,busy,err}=%b, required 000000",
               {awvalid, wvalid, bready, fifo_r_en, busy, err});
    end
    wready = 1'b1;
    a0 = aw_addr_q.size();
    w0 = w_data_q.size();
    tick();
    push_bytes(8'h50, 16);
    wait_idle("middata", 200);
    n_checks++;
    if (aw_addr_q.size() != a0 + 1 || w_data_q.size() != w0 + 4) begin
      n_fail++;
      $display("FAIL middata_counts: aw=%0d w=%0d, required 1 4", aw_addr_q.size() - a0, w_data_q.size() - w0);
    end else begin
      n_checks++;
      if (aw_addr_q[a0] !== 32'h1000 || w_data_q[w0] !== 32'h53525150) begin
        n_fail++;
        $display("FAIL middata_next: awaddr=%h beat0=%h, required 00001000 53525150", aw_addr_q[a0], w_data_q[w0]);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    int a0, w0;
    pulse_reset();
    a0 = aw_addr_q.size();
    w0 = w_data_q.size();
    push_bytes(8'h60, 48);
    wait_idle("wrap", 400);
    n_checks++;
    if (aw_addr_q.size() != a0 + 3 || w_data_q.size() != w0 + 12) begin
      n_fail++;
      $display("FAIL wrap_counts: aw=%0d w=%0d, required 3 12", aw_addr_q.size() - a0, w_data_q.size() - w0);
    end else begin
      n_checks++;
      if (aw_addr_q[a0] !== 32'h1000 || aw_addr_q[a0+1] !== 32'h1010 || aw_addr_q[a0+2] !== 32'h1000) begin
        n_fail++;
        $display("FAIL wrap_addrs: got %h %h %h, required 00001000 00001010 00001000",
                 aw_addr_q[a0], aw_addr_q[a0+1], aw_addr_q[a0+2]);
      end
      n_checks++;
      if (w_data_q[w0+11] !== 32'h8F8E8D8C || w_last_q[w0+11] !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_last_beat: data=%h last=%b, required 8f8e8d8c 1", w_data_q[w0+11], w_last_q[w0+11]);
      end
    end
  endtask

`ifdef DRAIN_FLUSH_EN
  task automatic test_flush();
    int a0, w0;
    pulse_reset();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_ignored: busy=%b, required 0", busy);
    end
    a0 = aw_addr_q.size();
    w0 = w_data_q.size();
    push_bytes(8'hA0, 6);
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (busy !== 1'b1 || aw_addr_q.size() != a0) begin
      n_fail++;
      $display("FAIL flush_stall: busy=%b aw=%0d, required 1 0", busy, aw_addr_q.size() - a0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("flush", 100);
    n_checks++;
    if (aw_addr_q.size() != a0 + 1 || w_data_q.size() != w0 + 2) begin
      n_fail++;
      $display("FAIL flush_counts: aw=%0d w=%0d, required 1 2", aw_addr_q.size() - a0, w_data_q.size() - w0);
    end else begin
      n_checks++;
      if (aw_addr_q[a0] !== 32'h1000 || aw_len_q[a0] !== 8'd1) begin
        n_fail++;
        $display("FAIL flush_aw: addr=%h len=%0d, required 00001000 1", aw_addr_q[a0], aw_len_q[a0]);
      end
      n_checks++;
      if (w_data_q[w0] !== 32'hA3A2A1A0 || w_strb_q[w0] !== 4'hF || w_last_q[w0] !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_beat0: data=%h strb=%h last=%b, required a3a2a1a0 f 0",
                 w_data_q[w0], w_strb_q[w0], w_last_q[w0]);
      end
      n_checks++;
      if (w_data_q[w0+1] !== 32'h0000A5A4 || w_strb_q[w0+1] !== 4'b0011 || w_last_q[w0+1] !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_beat1: data=%h strb=%h last=%b, required 0000a5a4 3 1",
                 w_data_q[w0+1], w_strb_q[w0+1], w_last_q[w0+1]);
      end
    end
    push_bytes(8'hB0, 16);
    wait_idle("flush_next", 200);
    n_checks++;
    if (aw_addr_q.size() != a0 + 2) begin
      n_fail++;
      $display("FAIL flush_next_count: got %0d, required 2", aw_addr_q.size() - a0);
    end else begin
      n_checks++;
      if (aw_addr_q[a0+1] !== 32'h1010 || aw_len_q[a0+1] !== 8'd3) begin
        n_fail++;
        $display("FAIL flush_next_aw: addr=%h len=%0d, required 00001010 3", aw_addr_q[a0+1], aw_len_q[a0+1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_burst();
    test_stall();
    test_err();
    test_reset_mid_data();
    test_back_to_back_wrap();
`ifdef DRAIN_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
